// File: rtl/fifo_pkg.sv
// Shared helpers and types for the programmable synchronous FIFO.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
  } fifo_status_t;

  function automatic int unsigned clog2_depth(input int unsigned depth);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < depth) w++;
    return w;
  endfunction

  // True when the parameter set describes a buildable FIFO.
  function automatic bit fifo_params_ok(input int data_width, input int depth,
                                        input int af_thresh, input int ae_thresh,
                                        input int fwft);
    if (data_width < 1) return 1'b0;
    if (depth < 2) return 1'b0;
    if ((depth & (depth - 1)) != 0) return 1'b0;
    if (af_thresh < 1 || af_thresh > depth) return 1'b0;
    if (ae_thresh < 0 || ae_thresh > depth - 1) return 1'b0;
    if (fwft != 0 && fwft != 1) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable thresholds, FWFT option, flush and
// exported occupancy count.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    wr_ack,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    full,
  output logic                    empty,
  output logic                    almostfull,
  output logic                    almostempty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = clog2_depth(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (!fifo_params_ok(DATA_WIDTH, DEPTH, AF_THRESH, AE_THRESH, FWFT)) begin : g_bad_params
    $fatal(1, "sync_fifo_prog: illegal parameter set");
  end

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_ack_q, wr_ack_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;
  fifo_status_t          status;

  // Acceptance uses the count at the start of the cycle, so a full FIFO
  // still accepts a read and an empty one still accepts a write.
  always_comb begin
    wr_acc = wr_en && (count_q != DEPTH_C) && !flush;
    rd_acc = rd_en && (count_q != '0) && !flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else       count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
  end

  always_comb begin
    wr_ack_d    = wr_acc;
    overflow_d  = wr_en && !flush && (count_q == DEPTH_C);
    underflow_d = rd_en && !flush && (count_q == '0);
    rd_valid_d  = rd_acc;
    dout_d      = rd_acc ? mem_rdata : dout_q;
  end

  always_comb begin
    status.full        = (count_q == DEPTH_C);
    status.empty       = (count_q == '0);
    status.almostfull  = (count_q >= AF_C);
    status.almostempty = (count_q <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      rd_valid_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      rd_valid_q  <= rd_valid_d;
      wr_ack_q    <= wr_ack_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && rst_n),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // In FWFT mode dout_q keeps the last popped word, shown only while empty.
  assign data_out    = (FWFT != 0 && !status.empty) ? mem_rdata : dout_q;
  assign rd_valid    = (FWFT != 0) ? !status.empty : rd_valid_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign full        = status.full;
  assign empty       = status.empty;
  assign almostfull  = status.almostfull;
  assign almostempty = status.almostempty;
  assign count       = count_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus and
// checks both against a queue-based model every cycle.
module tb_sync_fifo_prog;

  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] s_dout, f_dout;
  logic s_rv, s_ack, s_ovf, s_unf, s_full, s_empty, s_af, s_ae;
  logic f_rv, f_ack, f_ovf, f_unf, f_full, f_empty, f_af, f_ae;
  logic [3:0] s_count, f_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(s_dout), .rd_valid(s_rv), .wr_ack(s_ack), .overflow(s_ovf), .underflow(s_unf),
    .full(s_full), .empty(s_empty), .almostfull(s_af), .almostempty(s_ae), .count(s_count));

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(f_dout), .rd_valid(f_rv), .wr_ack(f_ack), .overflow(f_ovf), .underflow(f_unf),
    .full(f_full), .empty(f_empty), .almostfull(f_af), .almostempty(f_ae), .count(f_count));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is the queue length, contents are the queue.
  logic [DW-1:0] mq[$];
  bit model_valid = 0;
  logic [DW-1:0] m_dout;
  bit m_ack, m_ovf, m_unf, m_rv;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_ack = 0; m_ovf = 0; m_unf = 0; m_rv = 0;
      m_dout = '0;
      model_valid = 1;
    end else if (flush) begin
      mq.delete();
      m_ack = 0; m_ovf = 0; m_unf = 0; m_rv = 0;
    end else if (model_valid) begin
      bit wa, ra;
      wa = wr_en && (mq.size() < DEPTH);
      ra = rd_en && (mq.size() > 0);
      m_ack = wa;
      m_ovf = wr_en && !wa;
      m_unf = rd_en && !ra;
      m_rv = ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(data_in);
    end
  end

  int n;
  always @(negedge clk) begin
    if (model_valid) begin
      n = mq.size();
      chk("s_count", 32'(s_count), 32'(n));
      chk("s_full", 32'(s_full), 32'(n == DEPTH));
      chk("s_empty", 32'(s_empty), 32'(n == 0));
      chk("s_almostfull", 32'(s_af), 32'(n >= AF));
      chk("s_almostempty", 32'(s_ae), 32'(n <= AE));
      chk("s_wr_ack", 32'(s_ack), 32'(m_ack));
      chk("s_overflow", 32'(s_ovf), 32'(m_ovf));
      chk("s_underflow", 32'(s_unf), 32'(m_unf));
      chk("s_rd_valid", 32'(s_rv), 32'(m_rv));
      chk("s_data_out", 32'(s_dout), 32'(m_dout));
      chk("f_count", 32'(f_count), 32'(n));
      chk("f_full", 32'(f_full), 32'(n == DEPTH));
      chk("f_empty", 32'(f_empty), 32'(n == 0));
      chk("f_almostfull", 32'(f_af), 32'(n >= AF));
      chk("f_almostempty", 32'(f_ae), 32'(n <= AE));
      chk("f_wr_ack", 32'(f_ack), 32'(m_ack));
      chk("f_overflow", 32'(f_ovf), 32'(m_ovf));
      chk("f_underflow", 32'(f_unf), 32'(m_unf));
      chk("f_rd_valid", 32'(f_rv), 32'(n != 0));
      if (n != 0) chk("f_data_out", 32'(f_dout), 32'(mq[0]));
    end
  end

  task automatic step(input logic r, input logic f, input logic w,
                      input logic [DW-1:0] d, input logic rd);
    rst_n = r; flush = f; wr_en = w; data_in = d; rd_en = rd;
    @(posedge clk);
    #1;
    rst_n = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 0);
    chk("rst_count", 32'(s_count), 0);
    chk("rst_empty", 32'(s_empty), 1);
    chk("rst_almostempty", 32'(s_ae), 1);
    chk("rst_full", 32'(s_full), 0);
    chk("rst_almostfull", 32'(s_af), 0);
    chk("rst_data_out", 32'(s_dout), 0);

    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 1, DW'(i), 0);
      chk("fill_ack", 32'(s_ack), 1);
      chk("fill_count", 32'(s_count), 32'(i));
      chk("fill_af", 32'(s_af), 32'(i >= 6));
    end
    chk("fill_full", 32'(s_full), 1);
    step(1, 0, 1, 16'h0009, 0);
    chk("ovf_pulse", 32'(s_ovf), 1);
    chk("ovf_ack", 32'(s_ack), 0);
    chk("ovf_count", 32'(s_count), 8);

    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, '0, 1);
      chk("drain_data", 32'(s_dout), 32'(i));
      chk("drain_valid", 32'(s_rv), 1);
    end
    chk("drain_empty", 32'(s_empty), 1);
    step(1, 0, 0, '0, 1);
    chk("unf_pulse", 32'(s_unf), 1);
    chk("unf_hold", 32'(s_dout), 32'h0008);

    for (int i = 0; i < 4; i++) step(1, 0, 1, DW'(16'h10 + i), 0);
    step(1, 0, 1, 16'h0014, 1);
    chk("rw4_count", 32'(s_count), 4);
    chk("rw4_ack", 32'(s_ack), 1);
    chk("rw4_data", 32'(s_dout), 32'h10);
    for (int i = 0; i < 4; i++) step(1, 0, 1, DW'(16'h15 + i), 0);
    step(1, 0, 1, 16'h0019, 1);
    chk("rwfull_ovf", 32'(s_ovf), 1);
    chk("rwfull_count", 32'(s_count), 7);
    chk("rwfull_data", 32'(s_dout), 32'h11);
    for (int i = 0; i < 7; i++) step(1, 0, 0, '0, 1);
    step(1, 0, 1, 16'h0020, 1);
    chk("rwempty_unf", 32'(s_unf), 1);
    chk("rwempty_ack", 32'(s_ack), 1);
    chk("rwempty_count", 32'(s_count), 1);
    step(1, 0, 1, 16'h0021, 0);
    step(1, 0, 1, 16'h0022, 0);

    // Interleaved traffic holding occupancy in 3..5 so pointers wrap.
    for (int i = 0; i < 20; i++) begin
      int c, op;
      c = mq.size();
      op = $urandom_range(0, 2);
      if (c <= 3) step(1, 0, 1, DW'($urandom), op[0]);
      else if (c >= 5) step(1, 0, op[0], DW'($urandom), 1);
      else step(1, 0, op != 1, DW'($urandom), op != 0);
    end
    chk("wrap_range", 32'(s_count >= 3 && s_count <= 5), 1);

    step(1, 1, 0, '0, 0);
    step(1, 0, 1, 16'hAAAA, 0);
    chk("fwft_data", 32'(f_dout), 32'hAAAA);
    chk("fwft_valid", 32'(f_rv), 1);
    step(1, 0, 0, '0, 1);
    chk("fwft_pop_valid", 32'(f_rv), 0);
    chk("fwft_pop_empty", 32'(f_empty), 1);
    chk("std_pop_data", 32'(s_dout), 32'hAAAA);

    for (int i = 0; i < 5; i++) step(1, 0, 1, DW'(16'h30 + i), 0);
    step(1, 1, 1, 16'h0035, 0);
    chk("flush_count", 32'(s_count), 0);
    chk("flush_empty", 32'(s_empty), 1);
    chk("flush_ack", 32'(s_ack), 0);
    chk("flush_data", 32'(s_dout), 32'hAAAA);

    for (int i = 0; i < 3; i++) step(1, 0, 1, DW'(16'h40 + i), 0);
    step(1, 0, 0, '0, 1);
    step(0, 0, 1, 16'h0050, 1);
    chk("mrst_count", 32'(s_count), 0);
    chk("mrst_data", 32'(s_dout), 0);
    chk("mrst_pulses", 32'({s_ack, s_ovf, s_unf, s_rv}), 0);

    for (int i = 0; i < 2000; i++) begin
      int wp, rp;
      wp = ((i / 100) % 2 == 0) ? 75 : 35;
      rp = 110 - wp;
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 99) < wp), DW'($urandom), ($urandom_range(0, 99) < rp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
